// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter with a one-word holding buffer.
// Frames go out LSB first as start, data, optional parity and 1 or 2 stop
// bits. Because of the holding buffer, consecutive frames leave the line
// with no idle gap between them.
// Ports:
//   i_clk       system clock
//   i_rst       synchronous reset, active-high
//   i_txDv      input word valid (taken when o_txReady=1)
//   i_txByte    word to transmit
//   o_txReady   holding buffer empty, so a word can be accepted this cycle
//   o_tx        serial line, idle high
//   o_txActive  high while any frame bit is on the line
//   o_txDone    one-cycle pulse after the final stop bit of each frame
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT  = 217,
  parameter int unsigned NUM_DATA_BITS = 8,
  parameter int unsigned PARITY_MODE   = 0,
  parameter int unsigned NUM_STOP_BITS = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_txDv,
  input  logic [NUM_DATA_BITS-1:0] i_txByte,
  output logic                     o_txReady,
  output logic                     o_tx,
  output logic                     o_txActive,
  output logic                     o_txDone
);

  localparam int unsigned STOP_CLKS = CLKS_PER_BIT * NUM_STOP_BITS;
  localparam int unsigned CNT_W     = (STOP_CLKS > 1) ? $clog2(STOP_CLKS) : 1;
  localparam int unsigned BIT_W     = $clog2(NUM_DATA_BITS + 1);
  localparam int unsigned DW        = NUM_DATA_BITS;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(NUM_DATA_BITS - 1);
  localparam logic             ODD_PAR   = 1'(PARITY_MODE == 1);
  localparam logic             HAS_PAR   = 1'(PARITY_MODE != 0);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    PARITY_BIT = 3'd3,
    STOP_BIT   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]    shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [DW-1:0]    buf_q, buf_d;
  logic             buf_full_q, buf_full_d;
  logic             ready_q, ready_d;
  logic             tx_q, tx_d;
  logic             active_q, active_d;
  logic             done_q, done_d;
  logic             load_c;
  logic             take_c;

  // State register; reset discards the buffer and drops any frame in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      ready_q    <= 1'b1;
      tx_q       <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      ready_q    <= ready_d;
      tx_q       <= tx_d;
      active_q   <= active_d;
      done_q     <= done_d;
    end
  end

  // Next-state, buffer and registered-output logic.
  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    done_d     = 1'b0;
    load_c     = 1'b0;
    take_c     = ready_q & i_txDv;
    tx_d       = 1'b1;
    active_d   = 1'b0;

    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (buf_full_q) load_c = 1'b1;
      end
      START_BIT: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = DATA_BITS;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      DATA_BITS: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == DATA_LAST) begin
            state_d = HAS_PAR ? PARITY_BIT : STOP_BIT;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            shift_d   = shift_q >> 1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      PARITY_BIT: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          state_d   = STOP_BIT;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      STOP_BIT: begin
        // The stop period spans all stop bits in one count.
        if (clk_cnt_q == STOP_LAST) begin
          clk_cnt_d = '0;
          done_d    = 1'b1;
          if (buf_full_q) load_c = 1'b1;
          else            state_d = IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
    endcase

    // Move the buffered word into the shift register; parity is frozen here.
    if (load_c) begin
      state_d    = START_BIT;
      shift_d    = buf_q;
      parity_d   = (^buf_q) ^ ODD_PAR;
      buf_full_d = 1'b0;
      clk_cnt_d  = '0;
      bit_cnt_d  = '0;
    end

    // Accept only while empty; load and accept never coincide.
    if (take_c) begin
      buf_d      = i_txByte;
      buf_full_d = 1'b1;
    end

    ready_d = ~buf_full_d;

    // Line level follows the state being entered so o_tx stays registered.
    case (state_d)
      START_BIT: begin
        tx_d     = 1'b0;
        active_d = 1'b1;
      end
      DATA_BITS: begin
        tx_d     = shift_d[0];
        active_d = 1'b1;
      end
      PARITY_BIT: begin
        tx_d     = parity_d;
        active_d = 1'b1;
      end
      STOP_BIT: begin
        tx_d     = 1'b1;
        active_d = 1'b1;
      end
      default: begin
        tx_d     = 1'b1;
        active_d = 1'b0;
      end
    endcase
  end

  assign o_txReady  = ready_q;
  assign o_tx       = tx_q;
  assign o_txActive = active_q;
  assign o_txDone   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: checks uart_tx across several parameter sets. All instances
// share the same stimulus; only the instance selected by 'cur' is observed.
// A uart_rx model decodes the line into a queue that is matched against the
// words pushed when they were accepted.
module tb_uart_tx;

  localparam int NCFG = 5;
  localparam int unsigned CPB_T [NCFG] = '{217, 4, 4, 4, 4};
  localparam int unsigned PAR_T [NCFG] = '{0, 0, 2, 1, 0};
  localparam int unsigned NSB_T [NCFG] = '{1, 1, 1, 1, 2};

  typedef struct packed {
    logic [7:0] data;
    logic       par;
    logic       start_ok;
    logic       stop_ok;
  } rx_t;

  typedef struct {
    logic [2:0] cfg;
    logic [7:0] word;
    int         frame_len;
    logic       par;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            dv;
  logic [7:0]      din;
  logic [NCFG-1:0] rdy_v, tx_v, act_v, done_v;
  logic [2:0]      cur;
  logic            rdy_c, tx_c, act_c, done_c;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  rx_t        rx_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    uart_tx #(
      .CLKS_PER_BIT (CPB_T[g]),
      .NUM_DATA_BITS(8),
      .PARITY_MODE  (PAR_T[g]),
      .NUM_STOP_BITS(NSB_T[g])
    ) u_dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_txDv    (dv),
      .i_txByte  (din),
      .o_txReady (rdy_v[g]),
      .o_tx      (tx_v[g]),
      .o_txActive(act_v[g]),
      .o_txDone  (done_v[g])
    );
  end

  assign rdy_c  = rdy_v[cur];
  assign tx_c   = tx_v[cur];
  assign act_c  = act_v[cur];
  assign done_c = done_v[cur];

  // Done pulses and lengths of continuous o_txActive runs.
  int done_cnt = 0;
  int runs     = 0;
  int last_run = 0;
  int run_len  = 0;
  always @(negedge clk) begin
    if (done_c === 1'b1) done_cnt++;
    if (act_c === 1'b1) run_len++;
    else if (run_len != 0) begin
      last_run = run_len;
      runs++;
      run_len = 0;
    end
  end

  // uart_rx model: mid-bit sampling; a frame cut short by o_txActive dropping
  // is discarded.
  logic rx_ab;
  rx_t  rx_r;
  int   rx_cpb, rx_half;

  task automatic rx_wait(input int n, inout logic ab);
    repeat (n) begin
      @(negedge clk);
      if (act_c !== 1'b1) ab = 1'b1;
    end
  endtask

  initial begin : rx_model
    forever begin
      @(negedge clk);
      if (tx_c === 1'b0 && act_c === 1'b1) begin
        rx_cpb  = int'(CPB_T[cur]);
        rx_half = rx_cpb / 2;
        rx_ab   = 1'b0;
        rx_r    = '0;
        rx_r.start_ok = 1'b1;
        rx_r.stop_ok  = 1'b1;
        rx_wait(rx_half, rx_ab);
        if (tx_c !== 1'b0) rx_r.start_ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          rx_wait(rx_cpb, rx_ab);
          rx_r.data[i] = tx_c;
        end
        if (PAR_T[cur] != 0) begin
          rx_wait(rx_cpb, rx_ab);
          rx_r.par = tx_c;
        end
        for (int s = 0; s < int'(NSB_T[cur]); s++) begin
          rx_wait(rx_cpb, rx_ab);
          if (tx_c !== 1'b1) rx_r.stop_ok = 1'b0;
        end
        rx_wait(rx_cpb - rx_half - 1, rx_ab);
        if (!rx_ab) rx_q.push_back(rx_r);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cfg %0d, t=%0t)", name, act, exp, cur, $time);
    end
  endtask

  // Present a word and wait until the instance takes it.
  task automatic send(input logic [7:0] w);
    int n;
    n   = 0;
    dv  = 1'b1;
    din = w;
    while (rdy_c !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (rdy_c !== 1'b1) begin
      check("ready_wait", 32'(rdy_c), 32'd1);
    end else begin
      exp_q.push_back(w);
      @(negedge clk);
    end
  endtask

  task automatic idle_inputs();
    dv  = 1'b0;
    din = 8'($urandom);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_count", 32'(done_cnt), 32'(target));
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
  endtask

  // Scoreboard: every accepted word must come out of the rx model in order.
  task automatic drain();
    logic [7:0] w;
    rx_t        r;
    logic       ep;
    check("rx_frame_count", 32'(rx_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      w = exp_q.pop_front();
      r = rx_q.pop_front();
      check("rx_data", 32'(r.data), 32'(w));
      check("rx_framing", 32'({r.start_ok, r.stop_ok}), 32'(2'b11));
      if (PAR_T[cur] != 0) begin
        ep = (^w) ^ (PAR_T[cur] == 1);
        check("rx_parity", 32'(r.par), 32'(ep));
      end
    end
    exp_q.delete();
    rx_q.delete();
  endtask

  vec_t vecs[7];
  int   b_done, b_runs, low_cnt;

  initial begin : main
    vecs[0] = '{cfg: 3'd0, word: 8'hA5, frame_len: 2170, par: 1'b0};
    vecs[1] = '{cfg: 3'd1, word: 8'h5A, frame_len: 40,   par: 1'b0};
    vecs[2] = '{cfg: 3'd2, word: 8'h07, frame_len: 44,   par: 1'b1};
    vecs[3] = '{cfg: 3'd3, word: 8'h07, frame_len: 44,   par: 1'b0};
    vecs[4] = '{cfg: 3'd4, word: 8'hFF, frame_len: 44,   par: 1'b0};
    vecs[5] = '{cfg: 3'd2, word: 8'h00, frame_len: 44,   par: 1'b0};
    vecs[6] = '{cfg: 3'd3, word: 8'h00, frame_len: 44,   par: 1'b1};

    cur = 3'd0;
    rst = 1'b1;
    dv  = 1'b0;
    din = 8'h00;
    repeat (2) @(negedge clk);

    // Single frames: reset state, accept/start latency, length, parity, data.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      cur = vecs[v].cfg;
      check("reset_state", 32'({tx_c, act_c, rdy_c, done_c}), 32'(4'b1010));
      rst = 1'b0;
      @(negedge clk);
      b_done = done_cnt;
      send(vecs[v].word);
      check("after_accept", 32'({tx_c, act_c, rdy_c}), 32'(3'b100));
      idle_inputs();
      @(negedge clk);
      check("start_bit", 32'({tx_c, act_c, rdy_c}), 32'(3'b011));
      wait_done(b_done + 1, vecs[v].frame_len + 100);
      check("frame_len", 32'(last_run), 32'(vecs[v].frame_len));
      if (PAR_T[cur] != 0 && rx_q.size() > 0)
        check("parity_bit", 32'(rx_q[0].par), 32'(vecs[v].par));
      drain();
    end

    // Back-to-back: second word buffered mid-frame, no gap between frames.
    do_reset();
    cur = 3'd1;
    rst = 1'b0;
    @(negedge clk);
    b_done = done_cnt;
    b_runs = runs;
    send(8'h3C);
    send(8'hC3);
    check("b2b_buffer_full", 32'({act_c, rdy_c}), 32'(2'b10));
    idle_inputs();
    repeat (28) @(negedge clk);
    check("b2b_ready_low", 32'({act_c, rdy_c}), 32'(2'b10));
    wait_done(b_done + 2, 300);
    check("b2b_run_len", 32'(last_run), 32'd80);
    check("b2b_runs", 32'(runs), 32'(b_runs + 1));
    drain();

    // Valid held high across three words.
    do_reset();
    rst = 1'b0;
    @(negedge clk);
    b_done = done_cnt;
    send(8'h01);
    send(8'h02);
    send(8'h03);
    check("third_after_frame1", 32'(done_cnt), 32'(b_done + 1));
    idle_inputs();
    wait_done(b_done + 3, 400);
    check("hold_run_len", 32'(last_run), 32'd120);
    drain();

    // Reset during data bit 3 with the buffer full.
    do_reset();
    rst = 1'b0;
    @(negedge clk);
    send(8'h11);
    send(8'h22);
    idle_inputs();
    repeat (15) @(negedge clk);
    check("pre_reset_state", 32'({act_c, rdy_c}), 32'(2'b10));
    b_done = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset_state", 32'({tx_c, act_c, rdy_c, done_c}), 32'(4'b1010));
    rst = 1'b0;
    exp_q.delete();
    low_cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_c !== 1'b1 || act_c !== 1'b0) low_cnt++;
    end
    check("post_reset_line_idle", 32'(low_cnt), 32'd0);
    check("post_reset_no_done", 32'(done_cnt), 32'(b_done));
    check("post_reset_no_frame", 32'(rx_q.size()), 32'd0);
    send(8'h96);
    idle_inputs();
    wait_done(b_done + 1, 200);
    check("post_reset_len", 32'(last_run), 32'd40);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
